// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - op encodings and return-address-stack bounds for pc_unit
package pc_unit_pkg;

    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_REL  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    localparam int RAS_DEPTH_MIN = 2;
    localparam int RAS_DEPTH_MAX = 16;
    localparam int RAS_CNT_W     = 5;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with overflow discard and sticky flags
import pc_unit_pkg::*;

module pc_ras #(
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [AW-1:0]        i_data,
    output logic [AW-1:0]        o_top,
    output logic [RAS_CNT_W-1:0] o_count,
    output logic                 o_ovf,
    output logic                 o_unf
);

    localparam int                   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]        LAST_IDX = PW'(DEPTH - 1);
    localparam logic [RAS_CNT_W-1:0] FULL_CNT = RAS_CNT_W'(DEPTH);

    logic [AW-1:0]        r_mem [DEPTH];
    logic [PW-1:0]        r_top;
    logic [RAS_CNT_W-1:0] r_count;
    logic                 r_ovf;
    logic                 r_unf;

    logic          w_empty;
    logic          w_full;
    logic          w_do_pop;
    logic [PW-1:0] w_top_inc;
    logic [PW-1:0] w_top_dec;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_top_inc = (r_top == LAST_IDX) ? '0 : r_top + PW'(1);
    assign w_top_dec = (r_top == '0) ? LAST_IDX : r_top - PW'(1);

    // A push while full lands on the oldest slot, which is what discards it.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (i_push) begin
            r_top <= w_top_inc;
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + RAS_CNT_W'(1);
            end
        end else if (i_pop) begin
            if (w_do_pop) begin
                r_top   <= w_top_dec;
                r_count <= r_count - RAS_CNT_W'(1);
            end else begin
                r_unf <= 1'b1;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst_n && i_push) begin
            r_mem[w_top_inc] <= i_data;
        end
    end

    assign o_top   = r_mem[r_top];
    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with inc/load/relative/call/return and a return-address stack
import pc_unit_pkg::*;

module pc_unit #(
    parameter int            AW           = 16,
    parameter int            RAS_DEPTH    = 4,
    parameter logic [AW-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pcce,
    input  logic [2:0]           op,
    input  logic [AW-1:0]        alu,
    input  logic [AW-1:0]        offset,
    output logic [AW-1:0]        pc,
    output logic [RAS_CNT_W-1:0] ras_count,
    output logic                 ras_empty,
    output logic                 ras_full,
    output logic                 ras_ovf,
    output logic                 ras_unf
);

    localparam logic [RAS_CNT_W-1:0] FULL_CNT = RAS_CNT_W'(RAS_DEPTH);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_ras_top;
    logic          w_push;
    logic          w_pop;

    assign w_pc_inc = r_pc + AW'(1);
    assign w_push   = pcce && (op == OP_CALL);
    assign w_pop    = pcce && (op == OP_RET);

    pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_ras_top),
        .o_count (ras_count),
        .o_ovf   (ras_ovf),
        .o_unf   (ras_unf)
    );

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == FULL_CNT);

    always_comb begin
        w_pc_next = w_pc_inc;
        case (op)
            OP_LOAD: w_pc_next = alu;
            OP_REL:  w_pc_next = r_pc + offset;
            OP_CALL: w_pc_next = alu;
            OP_RET:  w_pc_next = ras_empty ? w_pc_inc : w_ras_top;
            default: w_pc_next = w_pc_inc;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_VECTOR;
        end else if (pcce) begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a queue-based reference model
module tb_pc_unit;

    localparam int          AW    = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RV    = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        pcce;
    logic [2:0]  op;
    logic [15:0] alu;
    logic [15:0] offset;
    logic [15:0] pc;
    logic [4:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_ovf;
    logic        m_unf;

    pc_unit #(
        .AW           (AW),
        .RAS_DEPTH    (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pcce      (pcce),
        .op        (op),
        .alu       (alu),
        .offset    (offset),
        .pc        (pc),
        .ras_count (ras_count),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Drive one operation, advance the model, then let the DUT take its falling edge.
    task automatic apply(input logic r, input logic ce, input logic [2:0] o,
                         input logic [15:0] a, input logic [15:0] off);
        rst_n  = r;
        pcce   = ce;
        op     = o;
        alu    = a;
        offset = off;
        if (!r) begin
            m_pc = RV;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (ce) begin
            case (o)
                3'd1: m_pc = a;
                3'd2: m_pc = m_pc + off;
                3'd3: begin
                    if (m_stack.size() == DEPTH) begin
                        void'(m_stack.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_stack.push_back(m_pc + 16'd1);
                    m_pc = a;
                end
                3'd4: begin
                    if (m_stack.size() == 0) begin
                        m_pc  = m_pc + 16'd1;
                        m_unf = 1'b1;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end
                default: m_pc = m_pc + 16'd1;
            endcase
        end
        @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b1, 3'd3, 16'h1234, 16'h0000);
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 16'h0000); end
        n_checks++; if (ras_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
        n_checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full got=%b%b exp=10", ras_empty, ras_full); end
        n_checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", ras_ovf, ras_unf); end
        for (int i = 1; i <= 3; i++) begin
            apply(1'b1, 1'b1, 3'd0, 16'h0000, 16'h0000);
            n_checks++; if (pc !== 16'(i)) begin n_fail++; $display("FAIL inc_%0d got=%h exp=%h", i, pc, 16'(i)); end
            n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL inc_empty_%0d got=%b exp=1", i, ras_empty); end
        end
    endtask

    task automatic test_wrap();
        apply(1'b1, 1'b1, 3'd1, 16'hFFFF, 16'h0000);
        apply(1'b1, 1'b1, 3'd0, 16'h0000, 16'h0000);
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap got=%h exp=0000", pc); end
        apply(1'b1, 1'b1, 3'd1, 16'h0010, 16'h0000);
        apply(1'b1, 1'b1, 3'd2, 16'h0000, 16'hFFF0);
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rel_wrap got=%h exp=0000", pc); end
        apply(1'b1, 1'b1, 3'd2, 16'h0000, 16'h0123);
        n_checks++; if (pc !== 16'h0123) begin n_fail++; $display("FAIL rel_fwd got=%h exp=0123", pc); end
    endtask

    task automatic test_call_ret();
        logic [15:0] exp_pc [4];
        logic [4:0]  exp_cnt [4];
        logic [2:0]  ops [4];
        logic [15:0] tgt [4];
        exp_pc  = '{16'h0200, 16'h0300, 16'h0201, 16'h0101};
        exp_cnt = '{5'd1, 5'd2, 5'd1, 5'd0};
        ops     = '{3'd3, 3'd3, 3'd4, 3'd4};
        tgt     = '{16'h0200, 16'h0300, 16'h0000, 16'h0000};
        apply(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        apply(1'b1, 1'b1, 3'd1, 16'h0100, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, ops[i], tgt[i], 16'h0000);
            n_checks++; if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL call_ret_pc_%0d got=%h exp=%h", i, pc, exp_pc[i]); end
            n_checks++; if (ras_count !== exp_cnt[i]) begin n_fail++; $display("FAIL call_ret_cnt_%0d got=%0d exp=%0d", i, ras_count, exp_cnt[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_ret [4];
        exp_ret = '{16'h0041, 16'h0031, 16'h0021, 16'h0011};
        apply(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        for (int i = 1; i <= 5; i++) begin
            apply(1'b1, 1'b1, 3'd3, 16'(i * 16), 16'h0000);
            if (i == 4) begin
                n_checks++; if (ras_full !== 1'b1 || ras_ovf !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf got=%b%b exp=10", ras_full, ras_ovf); end
            end
        end
        n_checks++; if (ras_full !== 1'b1 || ras_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flags got=%b%b exp=11", ras_full, ras_ovf); end
        n_checks++; if (ras_count !== 5'd4) begin n_fail++; $display("FAIL ovf_count got=%0d exp=4", ras_count); end
        n_checks++; if (pc !== 16'h0050) begin n_fail++; $display("FAIL ovf_jump got=%h exp=0050", pc); end
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 3'd4, 16'h0000, 16'h0000);
            n_checks++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ovf_ret_%0d got=%h exp=%h", i, pc, exp_ret[i]); end
        end
        n_checks++; if (ras_unf !== 1'b0 || ras_empty !== 1'b1) begin n_fail++; $display("FAIL drained got=%b%b exp=01", ras_unf, ras_empty); end
        apply(1'b1, 1'b1, 3'd4, 16'h0000, 16'h0000);
        n_checks++; if (pc !== 16'h0012) begin n_fail++; $display("FAIL unf_pc got=%h exp=0012", pc); end
        n_checks++; if (ras_unf !== 1'b1 || ras_count !== 5'd0) begin n_fail++; $display("FAIL unf_flag got=%b cnt=%0d exp=1 cnt=0", ras_unf, ras_count); end
    endtask

    task automatic test_hold();
        apply(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        apply(1'b1, 1'b1, 3'd3, 16'h0500, 16'h0000);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 3'd3, 16'h0777, 16'h0000);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 3'd4, 16'h0000, 16'h0000);
        n_checks++; if (pc !== 16'h0500) begin n_fail++; $display("FAIL hold_pc got=%h exp=0500", pc); end
        n_checks++; if (ras_count !== 5'd1) begin n_fail++; $display("FAIL hold_count got=%0d exp=1", ras_count); end
        n_checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin n_fail++; $display("FAIL hold_flags got=%b%b exp=00", ras_ovf, ras_unf); end
        apply(1'b1, 1'b1, 3'd4, 16'h0000, 16'h0000);
        n_checks++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL hold_ret got=%h exp=0001", pc); end
    endtask

    task automatic test_reset_mid();
        apply(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        apply(1'b1, 1'b1, 3'd4, 16'h0000, 16'h0000);
        for (int i = 1; i <= 5; i++) apply(1'b1, 1'b1, 3'd3, 16'(i * 256), 16'h0000);
        apply(1'b1, 1'b1, 3'd4, 16'h0000, 16'h0000);
        apply(1'b1, 1'b1, 3'd4, 16'h0000, 16'h0000);
        n_checks++; if (ras_count !== 5'd2 || ras_ovf !== 1'b1 || ras_unf !== 1'b1) begin n_fail++; $display("FAIL pre_reset cnt=%0d flags=%b%b exp cnt=2 flags=11", ras_count, ras_ovf, ras_unf); end
        apply(1'b0, 1'b1, 3'd3, 16'h0999, 16'h0000);
        n_checks++; if (pc !== RV || ras_count !== 5'd0) begin n_fail++; $display("FAIL mid_reset pc=%h cnt=%0d exp pc=%h cnt=0", pc, ras_count, RV); end
        n_checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags got=%b%b exp=00", ras_ovf, ras_unf); end
        apply(1'b1, 1'b1, 3'd4, 16'h0000, 16'h0000);
        n_checks++; if (pc !== RV + 16'd1 || ras_unf !== 1'b1) begin n_fail++; $display("FAIL post_reset_ret pc=%h unf=%b exp pc=%h unf=1", pc, ras_unf, RV + 16'd1); end
    endtask

    task automatic test_random();
        int          v;
        logic        r;
        logic        ce;
        logic [2:0]  o;
        apply(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 79) != 0);
            ce = ($urandom_range(0, 3) != 0);
            v  = $urandom_range(0, 11);
            o  = (v > 7) ? ((v % 2 == 0) ? 3'd3 : 3'd4) : 3'(v);
            apply(r, ce, o, 16'($urandom), 16'($urandom));
            n_checks++;
            if (pc !== m_pc || ras_count !== 5'(m_stack.size())
                || ras_empty !== (m_stack.size() == 0) || ras_full !== (m_stack.size() == DEPTH)
                || ras_ovf !== m_ovf || ras_unf !== m_unf) begin
                n_fail++;
                $display("FAIL rand_%0d pc=%h cnt=%0d e/f=%b%b ovf/unf=%b%b exp pc=%h cnt=%0d ovf/unf=%b%b",
                         i, pc, ras_count, ras_empty, ras_full, ras_ovf, ras_unf,
                         m_pc, m_stack.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pcce   = 1'b0;
        op     = 3'd0;
        alu    = 16'h0000;
        offset = 16'h0000;
        m_pc   = RV;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        test_reset();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
